// File: rtl/code_entry_sequencer_if.sv
// Keypad-side and lock-side signals of the code entry sequencer.
//   sw, enter_btn, clear_btn : raw keypad inputs (asynchronous, buttons bouncy)
//   x                        : registered symbol stream to the lock
//   busy                     : high while a replay is in progress
//   entry_done               : one-cycle pulse after the last replayed symbol
//   digit_count              : symbols currently buffered
// Modports: master drives the keypad and observes the results; slave is the
// sequencer itself.
interface code_entry_sequencer_if #(
  parameter int CODE_LEN = 3
);
  logic [2:0]                      sw;
  logic                            enter_btn;
  logic                            clear_btn;
  logic [2:0]                      x;
  logic                            busy;
  logic                            entry_done;
  logic [$clog2(CODE_LEN+1)-1:0]   digit_count;

  modport master (
    output sw, enter_btn, clear_btn,
    input  x, busy, entry_done, digit_count
  );

  modport slave (
    input  sw, enter_btn, clear_btn,
    output x, busy, entry_done, digit_count
  );
endinterface

// File: rtl/code_entry_sequencer.sv
// Front end for the digital lock: synchronizes the keypad, debounces the
// ENTER/CLEAR buttons, collects CODE_LEN symbols and then replays them on x
// in back-to-back cycles (x rests at 3'b000 otherwise).
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset, clears all state
//   bus   : slave side of code_entry_sequencer_if (keypad in, lock stream out)
module code_entry_sequencer #(
  parameter int CODE_LEN        = 3,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input logic                   clk,
  input logic                   reset,
  code_entry_sequencer_if.slave bus
);

  localparam int DC_W  = $clog2(CODE_LEN + 1);
  localparam int IDX_W = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DC_W-1:0]  DC_LAST  = DC_W'(CODE_LEN - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CODE_LEN - 1);

  typedef enum logic {COLLECT, REPLAY} state_t;

  // ---------------------------------------------------------------------------
  // Symbol switches: synchronized only, sampled when ENTER is accepted.
  // ---------------------------------------------------------------------------
  logic [2:0] sw_meta_reg;
  logic [2:0] sw_sync_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_meta_reg <= 3'b000;
      sw_sync_reg <= 3'b000;
    end else begin
      sw_meta_reg <= bus.sw;
      sw_sync_reg <= sw_meta_reg;
    end
  end

  // ---------------------------------------------------------------------------
  // Buttons: bit 0 = ENTER, bit 1 = CLEAR. Each gets a synchronizer, a
  // debounce counter and a rising-edge detector on the debounced level.
  // ---------------------------------------------------------------------------
  logic [1:0] btn_raw;
  logic [1:0] btn_press;

  assign btn_raw = {bus.clear_btn, bus.enter_btn};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
      logic            meta_reg;
      logic            sync_reg;
      logic            deb_reg;
      logic            deb_dly_reg;
      logic [DB_W-1:0] cnt_reg;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          meta_reg    <= 1'b0;
          sync_reg    <= 1'b0;
          deb_reg     <= 1'b0;
          deb_dly_reg <= 1'b0;
          cnt_reg     <= '0;
        end else begin
          meta_reg    <= btn_raw[gi];
          sync_reg    <= meta_reg;
          deb_dly_reg <= deb_reg;
          // Any cycle of agreement restarts the stability count, so short
          // bounces never accumulate into a level change.
          if (sync_reg == deb_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == DB_LAST) begin
            deb_reg <= sync_reg;
            cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + DB_W'(1);
          end
        end
      end

      assign btn_press[gi] = deb_reg & ~deb_dly_reg;
    end
  endgenerate

  logic enter_press;
  logic clear_press;

  assign enter_press = btn_press[0];
  assign clear_press = btn_press[1];

  // ---------------------------------------------------------------------------
  // Collect / replay FSM
  // ---------------------------------------------------------------------------
  state_t           state_reg, state_next;
  logic [DC_W-1:0]  digit_count_reg, digit_count_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [IDX_W-1:0] idx_inc;
  logic [2:0]       x_reg, x_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic             wr_en;
  logic [2:0]       buffer [CODE_LEN];

  assign idx_inc = idx_reg + IDX_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= COLLECT;
      digit_count_reg <= '0;
      idx_reg         <= '0;
      x_reg           <= 3'b000;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
    end else begin
      state_reg       <= state_next;
      digit_count_reg <= digit_count_next;
      idx_reg         <= idx_next;
      x_reg           <= x_next;
      busy_reg        <= busy_next;
      done_reg        <= done_next;
    end
  end

  // Symbol store, written at the slot named by digit_count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < CODE_LEN; i++) begin
        buffer[i] <= 3'b000;
      end
    end else begin
      for (int i = 0; i < CODE_LEN; i++) begin
        if (wr_en && (digit_count_reg == DC_W'(i))) begin
          buffer[i] <= sw_sync_reg;
        end
      end
    end
  end

  // x/busy are registered, so their next values are the symbol to show in the
  // following cycle. idx_reg tracks the symbol currently on x.
  always_comb begin
    state_next       = state_reg;
    digit_count_next = digit_count_reg;
    idx_next         = idx_reg;
    x_next           = 3'b000;
    busy_next        = 1'b0;
    done_next        = 1'b0;
    wr_en            = 1'b0;

    case (state_reg)
      COLLECT: begin
        if (clear_press) begin
          digit_count_next = '0;
        end else if (enter_press) begin
          wr_en = 1'b1;
          if (digit_count_reg == DC_LAST) begin
            digit_count_next = '0;
            state_next       = REPLAY;
            idx_next         = '0;
            busy_next        = 1'b1;
            // With a single-symbol code, slot 0 is being written right now,
            // so forward the captured symbol instead of the stale slot.
            x_next = (CODE_LEN == 1) ? sw_sync_reg : buffer[0];
          end else begin
            digit_count_next = digit_count_reg + DC_W'(1);
          end
        end
      end

      REPLAY: begin
        // Presses arriving here are dropped; their edge detectors keep running.
        if (idx_reg == IDX_LAST) begin
          state_next = COLLECT;
          done_next  = 1'b1;
        end else begin
          idx_next  = idx_inc;
          x_next    = buffer[idx_inc];
          busy_next = 1'b1;
        end
      end

      default: begin
        state_next = COLLECT;
      end
    endcase
  end

  assign bus.x           = x_reg;
  assign bus.busy        = busy_reg;
  assign bus.entry_done  = done_reg;
  assign bus.digit_count = digit_count_reg;

endmodule

// File: doc/code_entry_sequencer.md
# code_entry_sequencer

- Front-end stage that sits directly upstream of the digital lock FSM and drives its 3-bit symbol input `x`.
- Synchronizes and debounces raw keypad signals: a 3-bit symbol switch bank, an ENTER button and a CLEAR button.
- Buffers `CODE_LEN` entered symbols, then replays them on `x` in back-to-back cycles. The lock only advances on consecutive-cycle symbols.
- Between replays `x` is held at the neutral value 3'b000.

## Interface
Parameters:
- `CODE_LEN`, default 3: number of symbols collected per attempt; minimum 1.
- `DEBOUNCE_CYCLES`, default 16: consecutive stable cycles required before a debounced button changes; minimum 1.

Ports:
- `clk`  in  1  single system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset. Asserted (0) clears all state immediately. Deassertion is synchronous to `clk` externally.
- `sw`  in  3  raw symbol switches; asynchronous.
- `enter_btn`  in  1  raw ENTER button, active-high; asynchronous and bouncy.
- `clear_btn`  in  1  raw CLEAR button, active-high; asynchronous and bouncy.
- `x`  out  3  symbol stream to the lock. Registered. Equals 3'b000 when not replaying.
- `busy`  out  1  high during every replay cycle.
- `entry_done`  out  1  single-cycle pulse in the cycle after the last replayed symbol.
- `digit_count`  out  $clog2(CODE_LEN+1)  number of symbols currently buffered.

## Operation
- **Synchronization:** `sw`, `enter_btn` and `clear_btn` each pass through a 2-flop synchronizer.
- **Debounce, per button:**
  - Each button has its own counter of width $clog2(DEBOUNCE_CYCLES+1).
  - The counter increments while the synchronized value differs from the debounced value, and resets to 0 on any cycle where they match.
  - When the counter reaches `DEBOUNCE_CYCLES`, the debounced value takes the synchronized value and the counter returns to 0.
- **Press acceptance:**
  - A press is accepted in the cycle where the debounced value is 1 and its 1-cycle delayed copy is 0 (rising-edge detect).
  - A held button yields exactly one press; it must debounce low before another press can register.
- **Symbol capture:** on an accepted ENTER press, the synchronized `sw` value in that same cycle is the captured symbol. `sw` itself is not debounced.
- **FSM states:** COLLECT (reset state) and REPLAY.
- **COLLECT:**
  - Accepted ENTER: write the symbol to `buffer[digit_count]` and increment `digit_count`.
  - If `digit_count` was `CODE_LEN`-1, clear `digit_count` to 0 and go to REPLAY with replay index 0.
  - Accepted CLEAR: `digit_count` goes to 0; buffer contents are don't-care.
  - CLEAR and ENTER accepted in the same cycle: CLEAR wins and no symbol is stored.
- **REPLAY:**
  - Each cycle, `x` = `buffer[idx]`, `busy`=1 and `idx` increments.
  - After `idx` = `CODE_LEN`-1, return to COLLECT.
  - ENTER and CLEAR presses accepted during REPLAY are discarded, not queued. Their edge detectors still update.
- **`entry_done`:** asserted for exactly one cycle, the first COLLECT cycle after REPLAY.
- **Symbol 3'b000:** a legal symbol and is replayed verbatim; it is indistinguishable from idle on `x`.
- **Reset (`reset`=0), at any time including mid-REPLAY:**
  - Outputs: `x`=000, `busy`=0, `entry_done`=0, `digit_count`=0.
  - Internal state: state=COLLECT, all debounced values and counters 0, synchronizers 0, buffer 0.
  - A replay interrupted by reset is aborted, never resumed.

## Timing
- **Raw-press latency:** from a raw button edge that stays stable, the debounced value changes 2 + `DEBOUNCE_CYCLES` (±1) cycles later. The press is accepted in that same cycle.
- **Replay schedule:** for a final press accepted in cycle t:
  - `x` = `buffer[0]` in t+1, `buffer[1]` in t+2, …, `buffer[CODE_LEN-1]` in t+`CODE_LEN`.
  - `busy` is high over exactly the same cycles.
  - `entry_done`=1 and `x`=000 in t+`CODE_LEN`+1. COLLECT accepts presses again from t+`CODE_LEN`+1.
- **Output timing:** `x` never glitches between symbols; all outputs are driven from flops.
- **Lock timing:** with the default lock code the downstream lock asserts its `y` during t+`CODE_LEN`+1, coincident with `entry_done`.

## Test plan
All tests use `DEBOUNCE_CYCLES`=4 and `CODE_LEN`=3.
1. **Default code:** clean presses with `sw`=011, 111, 101 -> `x`=011, 111, 101 on three consecutive cycles; `busy`=1 for exactly those 3 cycles; `entry_done` pulses once in the next cycle with `x`=000; `digit_count` reads 0, 1, 2, 0 across the entry.
2. **Bounce rejection:** `enter_btn` toggles with 2-cycle pulses for 20 cycles, then holds 1 for 50 cycles -> exactly one symbol stored (`digit_count`=1); no second press until release plus 4 stable cycles.
3. **Clear:** enter 2 symbols, then CLEAR -> `digit_count`=0. Then enter 001, 010, 100 -> replay shows only 001, 010, 100.
4. **Collision:** ENTER and CLEAR debounce high in the same cycle with `digit_count`=1 -> `digit_count`=0; no symbol written.
5. **Ignored presses:** an ENTER press accepted during REPLAY cycle 2 -> `digit_count` stays 0 after replay; no extra symbol appears.
6. **Reset mid-replay:** `reset`=0 asserted during replay cycle 2 -> `x`=000 and `busy`=0 immediately (asynchronously); after release, `digit_count`=0 and no `entry_done` pulse.
